state_burst_gen: RTL and testbench
==================================

// Module: state_burst_gen
// PURPOSE
//   Parametrised FSM-driven burst source: on a start pulse, emits a configurable number
//   of data beats on a valid/ready stream, then reports completion. Generalises the
//   fixed IDLE/EXEC/DONE controller with width/length parameters, pattern modes,
//   backpressure, stall timeout and abort. Sits between control logic and stream sinks.
// PARAMETERS
//   DSIZE    8    data width of out_data and cfg_seed
//   LEN_W    8    width of cfg_len (max burst = 2**LEN_W-1 beats)
//   TIMEOUT  255  consecutive stalled cycles (valid & ~ready) before ERR; must be >= 1
// PORTS
//   clock      in   1      sole clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      pulse; accepted only in IDLE
//   abort      in   1      forces return to IDLE from any state
//   cfg_len    in   LEN_W  burst length in beats, sampled with start
//   cfg_seed   in   DSIZE  first data value, sampled with start
//   cfg_mode   in   1      0 = constant seed, 1 = incrementing from seed
//   out_valid  out  1      stream valid
//   out_ready  in   1      stream ready from sink
//   out_data   out  DSIZE  stream data
//   out_last   out  1      high on the final beat of the burst
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse on burst completion
//   err        out  1      one-cycle pulse on stall timeout
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0; beat and stall counters 0; config regs 0.
//   - All outputs registered. States: IDLE, EXEC, DONE, ERR.
//   - IDLE: start=1 latches cfg_*; cfg_len!=0 -> EXEC, cfg_len==0 -> DONE.
//     out_valid rises the cycle after start (latency 1); out_data = seed on first beat.
//   - start while busy is ignored (config not re-sampled).
//   - EXEC: out_valid=1. Transfer = out_valid & out_ready. On transfer: beat count +1,
//     out_data += 1 if mode 1 (wraps modulo 2**DSIZE), unchanged if mode 0.
//     out_data/out_last stable while valid & ~ready.
//   - out_last = 1 exactly when remaining beats == 1 (first beat if cfg_len==1).
//   - Transfer with out_last -> DONE; out_valid deasserts next cycle.
//   - Stall counter: +1 each cycle valid & ~ready, cleared on transfer and on leaving EXEC.
//     Reaching TIMEOUT -> ERR; out_valid drops next cycle (burst truncated).
//   - DONE: done=1 for one cycle, then IDLE. ERR: err=1 for one cycle, then IDLE.
//   - abort has priority over all transitions: next state IDLE, out_valid/out_last 0,
//     no done/err pulse, counters cleared. start coincident with abort is ignored.
//   - Ready transfer on the same cycle the stall counter would hit TIMEOUT: transfer
//     wins, counter clears, no ERR.
//   - Async reset mid-burst: immediate return to reset values; no done/err.
// TESTING
//   1 start, len=4, seed=8'h10, mode=1, ready=1 -> data 10,11,12,13 on 4 consecutive
//     cycles, last on 13, done pulse 1 cycle after, busy low after done.
//   2 len=3, seed=8'hFE, mode=1, ready toggling 1/0 -> FE,FF,00 (wrap), data held
//     during stalls, exactly 3 transfers, last on 00.
//   3 len=0 -> no out_valid, done pulse 2 cycles after start, busy high for 1 cycle.
//   4 TIMEOUT=4, len=5, ready=0 after first beat -> err pulse after 4 stalled cycles,
//     valid drops, no done; next start accepted normally.
//   5 abort on 2nd beat of len=6 burst -> valid 0 next cycle, IDLE, no done/err;
//     start during EXEC (mode/seed changed) has no effect on the running burst.
//   6 rst_n low mid-burst -> all outputs 0 asynchronously; mode=0, len=2, seed=8'hA5
//     after reset -> A5,A5.

Source files
------------

// File: rtl/state_burst_gen.sv
// Burst source: on start, streams cfg_len beats over valid/ready, then pulses done.
// Stall timeout pulses err, and abort returns to IDLE at any time.
module state_burst_gen #(
    parameter int DSIZE   = 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [DSIZE-1:0] cfg_seed,
    input  logic             cfg_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int ST_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [ST_W-1:0]  stall_q, stall_d;
    logic             valid_q, valid_d;
    logic [DSIZE-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic xfer;
    logic stall_hit;

    assign xfer      = valid_q & out_ready;
    assign stall_hit = valid_q & ~out_ready & (stall_q == ST_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = (cfg_len == '0) ? DONE : EXEC;
                    end
                end
                EXEC: begin
                    if (xfer && last_q) begin
                        state_d = DONE;
                    end else if (stall_hit) begin
                        state_d = ERR;
                    end
                end
                DONE:    state_d = IDLE;
                ERR:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        len_d   = len_q;
        mode_d  = mode_q;
        beat_d  = beat_q;
        stall_d = stall_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (abort) begin
            beat_d  = '0;
            stall_d = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        len_d   = cfg_len;
                        mode_d  = cfg_mode;
                        data_d  = cfg_seed;
                        beat_d  = '0;
                        stall_d = '0;
                        valid_d = (cfg_len != '0);
                        last_d  = (cfg_len == LEN_W'(1));
                    end
                end
                EXEC: begin
                    if (xfer) begin
                        stall_d = '0;
                        beat_d  = beat_q + LEN_W'(1);
                        if (last_q) begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end else begin
                            data_d = mode_q ? data_q + DSIZE'(1) : data_q;
                            // next beat is final when two beats beyond beat_q reach len
                            last_d = ({1'b0, beat_q} + (LEN_W+1)'(2))
                                     == {1'b0, len_q};
                        end
                    end else if (stall_hit) begin
                        stall_d = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        stall_d = stall_q + ST_W'(1);
                    end
                end
                default: begin
                    stall_d = '0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE) & ~abort;
        err_d  = (state_q == ERR) & ~abort;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            mode_q  <= 1'b0;
            beat_q  <= '0;
            stall_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            len_q   <= len_d;
            mode_q  <= mode_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_state_burst_gen.sv
// Directed bench for state_burst_gen (TIMEOUT=4).
// Expected beats, pulses and stalls are hand-computed per scenario.
module tb_state_burst_gen;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] cfg_len;
    logic [7:0] cfg_seed;
    logic       cfg_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    state_burst_gen #(
        .DSIZE(8),
        .LEN_W(8),
        .TIMEOUT(4)
    ) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .cfg_len  (cfg_len),
        .cfg_seed (cfg_seed),
        .cfg_mode (cfg_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic outs(input string tag, input logic v, input logic [7:0] d,
                        input logic l, input logic b, input logic dn,
                        input logic e);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) chk({tag, ".data"}, {24'd0, out_data}, {24'd0, d});
        chk({tag, ".last"}, {31'd0, out_last}, {31'd0, l});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
        chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
    endtask

    task automatic go(input logic [7:0] len, input logic [7:0] seed,
                      input logic mode);
        cfg_len  = len;
        cfg_seed = seed;
        cfg_mode = mode;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp2 [3];
        int         nx;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_len   = '0;
        cfg_seed  = '0;
        cfg_mode  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        outs("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.data", {24'd0, out_data}, 32'h0);
        rst_n = 1'b1;
        step();

        // 1: len 4, incrementing from 10, ready always high
        out_ready = 1'b1;
        go(8'd4, 8'h10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            outs($sformatf("t1.b%0d", i), 1'b1, 8'h10 + 8'(i), (i == 3),
                 1'b1, 1'b0, 1'b0);
            step();
        end
        outs("t1.donest", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        outs("t1.done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        outs("t1.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: wrap FE,FF,00 with toggling ready
        exp2[0] = 8'hFE;
        exp2[1] = 8'hFF;
        exp2[2] = 8'h00;
        nx = 0;
        go(8'd3, 8'hFE, 1'b1);
        for (int c = 0; c < 12 && nx < 3; c++) begin
            out_ready = (c % 2 == 1);
            chk($sformatf("t2.valid%0d", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("t2.data%0d", c), {24'd0, out_data},
                {24'd0, exp2[nx]});
            chk($sformatf("t2.last%0d", c), {31'd0, out_last},
                {31'd0, nx == 2});
            if (out_ready && out_valid) nx++;
            step();
        end
        chk("t2.xfers", nx, 3);
        out_ready = 1'b1;
        outs("t2.after", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        outs("t2.done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();

        // 3: zero-length burst
        go(8'd0, 8'h33, 1'b1);
        outs("t3.c1", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        outs("t3.c2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();

        // 4: stall timeout after first beat
        go(8'd5, 8'h20, 1'b1);
        outs("t4.b0", 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            outs($sformatf("t4.stall%0d", i), 1'b1, 8'h21, 1'b0, 1'b1,
                 1'b0, 1'b0);
            step();
        end
        outs("t4.errst", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        outs("t4.err", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b1;
        step();
        go(8'd1, 8'h07, 1'b0);
        outs("t4.next", 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        step();
        outs("t4.ndone", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();

        // 5: start ignored while busy, then abort on second beat
        go(8'd6, 8'h30, 1'b1);
        cfg_len  = 8'd2;
        cfg_seed = 8'h99;
        cfg_mode = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        outs("t5.b1", 1'b1, 8'h31, 1'b0, 1'b1, 1'b0, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        outs("t5.abort", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        outs("t5.quiet", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        abort = 1'b1;
        go(8'd3, 8'h44, 1'b1);
        abort = 1'b0;
        outs("t5.startab", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: async reset mid-burst, then constant mode
        go(8'd4, 8'h40, 1'b1);
        outs("t6.run", 1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        outs("t6.rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6.rstdata", {24'd0, out_data}, 32'h0);
        step();
        rst_n = 1'b1;
        go(8'd2, 8'hA5, 1'b0);
        outs("t6.b0", 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        outs("t6.b1", 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        outs("t6.donest", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        outs("t6.done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
